// File: rtl/prog_run_ctrl.sv
// Run sequencer: arms on Start, launches the selected program with a one-cycle
// PC load, gates PC counting during the run, and stops on halt or cycle budget.
module prog_run_ctrl #(
    parameter int unsigned      PC_W       = 10,
    parameter int unsigned      CNT_W      = 16,
    parameter logic [CNT_W-1:0] MAX_CYCLES = 16'd50000,
    parameter int unsigned      NUM_PROGS  = 3,
    parameter logic [PC_W-1:0]  START0     = '0,
    parameter logic [PC_W-1:0]  START1     = '0,
    parameter logic [PC_W-1:0]  START2     = '0,
    parameter logic [PC_W-1:0]  START3     = '0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             HaltReq,
    input  logic             StallReq,
    output logic             CountEn,
    output logic             PcLoad,
    output logic [PC_W-1:0]  StartAddr,
    output logic [1:0]       ProgIdx,
    output logic             Ack,
    output logic             Timeout,
    output logic [CNT_W-1:0] CycleCnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_LOAD,
        S_RUN,
        S_HALTED
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CYCLE = MAX_CYCLES - CNT_W'(1);
    localparam logic [1:0]       LAST_PROG  = 2'(NUM_PROGS - 1);

    state_t state;
    state_t state_nxt;
    logic   budget_end;

    // The final budgeted RUN cycle; reaching it forces a halt.
    assign budget_end = (CycleCnt == LAST_CYCLE);

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the PC control strobes.
    always_comb begin
        state_nxt = state;
        CountEn   = 1'b0;
        PcLoad    = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (!Start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                PcLoad    = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                CountEn = ~StallReq & ~HaltReq;
                if (HaltReq || budget_end) state_nxt = S_HALTED;
            end
            S_HALTED: begin
                if (Start) state_nxt = S_ARMED;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run bookkeeping: cycle count, completion/timeout flags, program index.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ProgIdx  <= '0;
            CycleCnt <= '0;
            Ack      <= 1'b0;
            Timeout  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    CycleCnt <= '0;
                    Timeout  <= 1'b0;
                    Ack      <= 1'b0;
                end
                S_RUN: begin
                    CycleCnt <= CycleCnt + CNT_W'(1);
                    if (HaltReq) begin
                        Ack <= 1'b1;
                    end else if (budget_end) begin
                        Ack     <= 1'b1;
                        Timeout <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (Start) begin
                        Ack     <= 1'b0;
                        ProgIdx <= (ProgIdx == LAST_PROG) ? '0 : ProgIdx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Start address of the current program.
    always_comb begin
        case (ProgIdx)
            2'd0:    StartAddr = START0;
            2'd1:    StartAddr = START1;
            2'd2:    StartAddr = START2;
            default: StartAddr = START3;
        endcase
    end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: reset, halted run, stalls, budget timeout,
// program sequencing with wrap, and mid-run reset.
module tb_prog_run_ctrl;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned MAXC  = 24;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             Start;
    logic             HaltReq;
    logic             StallReq;
    logic             CountEn;
    logic             PcLoad;
    logic [PC_W-1:0]  StartAddr;
    logic [1:0]       ProgIdx;
    logic             Ack;
    logic             Timeout;
    logic [CNT_W-1:0] CycleCnt;

    int n_cmp = 0;
    int n_bad = 0;

    prog_run_ctrl #(
        .PC_W      (PC_W),
        .CNT_W     (CNT_W),
        .MAX_CYCLES(16'd24),
        .NUM_PROGS (3),
        .START0    (10'd0),
        .START1    (10'd40),
        .START2    (10'd90),
        .START3    (10'd0)
    ) u_dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .HaltReq  (HaltReq),
        .StallReq (StallReq),
        .CountEn  (CountEn),
        .PcLoad   (PcLoad),
        .StartAddr(StartAddr),
        .ProgIdx  (ProgIdx),
        .Ack      (Ack),
        .Timeout  (Timeout),
        .CycleCnt (CycleCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        int en_cnt;

        Reset_n  = 1'b0;
        Start    = 1'b1;
        HaltReq  = 1'b0;
        StallReq = 1'b0;

        // Reset with Start held high
        cyc();
        cyc();
        check("rst_counten", 32'(CountEn), 0);
        check("rst_pcload", 32'(PcLoad), 0);
        check("rst_startaddr", 32'(StartAddr), 0);
        check("rst_progidx", 32'(ProgIdx), 0);
        check("rst_ack", 32'(Ack), 0);
        check("rst_timeout", 32'(Timeout), 0);
        check("rst_cyclecnt", 32'(CycleCnt), 0);
        Reset_n = 1'b1;
        cyc();  // ARMED
        check("armed_counten", 32'(CountEn), 0);
        check("armed_pcload", 32'(PcLoad), 0);
        cyc();  // still ARMED while Start high
        check("armed_hold_pcload", 32'(PcLoad), 0);

        // Run 0: halt on RUN cycle 20
        Start = 1'b0;
        cyc();  // LOAD
        check("r0_load_pcload", 32'(PcLoad), 1);
        check("r0_load_counten", 32'(CountEn), 0);
        check("r0_load_addr", 32'(StartAddr), 0);
        en_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            HaltReq = (i == 20);
            #1;
            if (CountEn) en_cnt++;
            if (i == 1) begin
                check("r0_first_counten", 32'(CountEn), 1);
                check("r0_run_pcload", 32'(PcLoad), 0);
                check("r0_cnt_start", 32'(CycleCnt), 0);
            end
            if (i == 20) check("r0_halt_counten", 32'(CountEn), 0);
        end
        cyc();  // HALTED
        HaltReq = 1'b0;
        check("r0_en_cycles", 32'(en_cnt), 19);
        check("r0_ack", 32'(Ack), 1);
        check("r0_timeout", 32'(Timeout), 0);
        check("r0_cyclecnt", 32'(CycleCnt), 20);
        check("r0_halt_en", 32'(CountEn), 0);
        cyc();
        cyc();
        check("r0_ack_held", 32'(Ack), 1);
        check("r0_cnt_held", 32'(CycleCnt), 20);

        // Run 1: stalls on cycles 6..10, halt on 10, Start toggling in RUN
        Start = 1'b1;
        cyc();  // ARMED
        check("r1_ack_clr", 32'(Ack), 0);
        check("r1_progidx", 32'(ProgIdx), 1);
        Start = 1'b0;
        cyc();  // LOAD
        check("r1_load_pcload", 32'(PcLoad), 1);
        check("r1_load_addr", 32'(StartAddr), 40);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            StallReq = (i >= 6);
            HaltReq  = (i == 10);
            Start    = i[0];
            #1;
            check($sformatf("r1_counten_%0d", i), 32'(CountEn), (i < 6) ? 1 : 0);
        end
        cyc();  // HALTED
        StallReq = 1'b0;
        HaltReq  = 1'b0;
        Start    = 1'b0;
        check("r1_ack", 32'(Ack), 1);
        check("r1_cyclecnt", 32'(CycleCnt), 10);
        check("r1_timeout", 32'(Timeout), 0);

        // Run 2: no halt, budget expires
        Start = 1'b1;
        cyc();
        check("r2_progidx", 32'(ProgIdx), 2);
        Start = 1'b0;
        cyc();  // LOAD
        check("r2_load_pcload", 32'(PcLoad), 1);
        check("r2_load_addr", 32'(StartAddr), 90);
        for (int i = 1; i <= int'(MAXC); i++) begin
            cyc();
            if (i == int'(MAXC)) begin
                check("r2_last_cnt", 32'(CycleCnt), MAXC - 1);
                check("r2_last_counten", 32'(CountEn), 1);
                check("r2_last_ack", 32'(Ack), 0);
            end
        end
        cyc();  // HALTED by budget
        check("r2_ack", 32'(Ack), 1);
        check("r2_timeout", 32'(Timeout), 1);
        check("r2_cyclecnt", 32'(CycleCnt), MAXC);
        check("r2_counten", 32'(CountEn), 0);
        cyc();
        check("r2_cnt_held", 32'(CycleCnt), MAXC);

        // Run 3: program index wraps, Timeout clears at LOAD
        Start = 1'b1;
        cyc();  // ARMED
        check("r3_progidx_wrap", 32'(ProgIdx), 0);
        check("r3_timeout_kept", 32'(Timeout), 1);
        Start = 1'b0;
        cyc();  // LOAD
        check("r3_load_pcload", 32'(PcLoad), 1);
        check("r3_load_addr", 32'(StartAddr), 0);
        cyc();  // RUN 1
        check("r3_timeout_clr", 32'(Timeout), 0);
        check("r3_cnt_start", 32'(CycleCnt), 0);
        for (int i = 2; i <= 8; i++) cyc();
        check("r3_cnt_7", 32'(CycleCnt), 7);

        // Reset mid-run
        Reset_n = 1'b0;
        cyc();
        check("mrst_counten", 32'(CountEn), 0);
        check("mrst_cyclecnt", 32'(CycleCnt), 0);
        check("mrst_progidx", 32'(ProgIdx), 0);
        check("mrst_ack", 32'(Ack), 0);
        Reset_n = 1'b1;
        cyc();
        cyc();
        check("mrst_idle_pcload", 32'(PcLoad), 0);
        check("mrst_idle_cnt", 32'(CycleCnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
